c3_src_loader: RTL and testbench

Stream-to-buffer loader that fills the six C3 source buffers through their shared write port (`wr_data`/`wr_addr`/`we`). It accepts the S2 output stream, one 16-bit word per handshake, in map-major order and writes each word to the correct buffer and word address. It is the writer for the C3 source buffer array and sits between the S2 pooling output and the C3 convolution stage.

---
 rtl/c3_pkg.sv | 28 ++
 rtl/c3_src_loader_if.sv | 24 ++
 rtl/c3_addr_gen.sv | 45 ++++
 rtl/c3_src_loader.sv | 99 +++++++++
 tb/tb_c3_src_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/c3_pkg.sv
// Shared definitions for the C3 source-buffer loader: buffer geometry,
// write-address field layout and the loader FSM state type.
package c3_pkg;

    localparam int C3_NUM_BUF       = 6;
    localparam int C3_WORDS_PER_BUF = 196;
    localparam int C3_DATA_W        = 16;
    localparam int C3_CNT_W         = 8;
    localparam int C3_WR_ADDR_W     = 32;
    localparam int C3_BUF_IDX_LSB   = 8;
    localparam int C3_WORD_ADDR_LSB = 0;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE
    } c3_ld_state_t;

    // Packs buffer index and word address into the shared write-port address.
    function automatic logic [C3_WR_ADDR_W-1:0] c3_wr_addr(
        input logic [C3_CNT_W-1:0] buf_idx,
        input logic [C3_CNT_W-1:0] word_addr
    );
        return (C3_WR_ADDR_W'(buf_idx)   << C3_BUF_IDX_LSB) |
               (C3_WR_ADDR_W'(word_addr) << C3_WORD_ADDR_LSB);
    endfunction

endpackage

// File: rtl/c3_src_loader_if.sv
// Stream input and buffer write port of the C3 source loader.
// slave = loader side, master = stream producer / buffer array side.
interface c3_src_loader_if
    import c3_pkg::*;
();

    logic                    in_valid;
    logic                    in_ready;
    logic [C3_DATA_W-1:0]    in_data;
    logic [C3_DATA_W-1:0]    wr_data;
    logic [C3_WR_ADDR_W-1:0] wr_addr;
    logic                    we;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_data, wr_addr, we
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_data, wr_addr, we
    );

endinterface

// File: rtl/c3_addr_gen.sv
// Nested word/buffer counter for the C3 source loader. `last` flags the
// final word of the final buffer; buf_cnt saturates at NUM_BUF-1.
module c3_addr_gen
    import c3_pkg::*;
#(
    parameter int NUM_BUF       = C3_NUM_BUF,
    parameter int WORDS_PER_BUF = C3_WORDS_PER_BUF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [C3_CNT_W-1:0] word_cnt,
    output logic [C3_CNT_W-1:0] buf_cnt,
    output logic                last
);

    localparam logic [C3_CNT_W-1:0] WORD_LAST = C3_CNT_W'(WORDS_PER_BUF - 1);
    localparam logic [C3_CNT_W-1:0] BUF_LAST  = C3_CNT_W'(NUM_BUF - 1);

    logic word_wrap;

    assign word_wrap = (word_cnt == WORD_LAST);
    assign last      = word_wrap && (buf_cnt == BUF_LAST);

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking here would create order-dependent logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            buf_cnt  <= '0;
        end else if (clr) begin
            word_cnt <= '0;
            buf_cnt  <= '0;
        end else if (inc) begin
            if (word_wrap) begin
                word_cnt <= '0;
                if (buf_cnt != BUF_LAST) buf_cnt <= buf_cnt + 1'b1;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/c3_src_loader.sv
// Loads the S2 output stream into the six C3 source buffers, map-major.
// Optional checksum enabled by defining C3_SRC_LOADER_CKSUM_EN.
module c3_src_loader
    import c3_pkg::*;
#(
    parameter int NUM_BUF       = C3_NUM_BUF,
    parameter int WORDS_PER_BUF = C3_WORDS_PER_BUF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    c3_src_loader_if.slave       bus,
    output logic                 busy,
    output logic                 done,
    output logic [C3_DATA_W-1:0] cksum
);

    c3_ld_state_t state, state_nxt;

    logic [C3_CNT_W-1:0]     word_cnt;
    logic [C3_CNT_W-1:0]     buf_cnt;
    logic                    last;
    logic                    accept;
    logic                    clr;
    logic                    we_q;
    logic [C3_WR_ADDR_W-1:0] wr_addr_q;
    logic [C3_DATA_W-1:0]    wr_data_q;

    assign accept = bus.in_valid && (state == LD_LOAD);
    assign clr    = (state == LD_IDLE) && start;

    c3_addr_gen #(
        .NUM_BUF       (NUM_BUF),
        .WORDS_PER_BUF (WORDS_PER_BUF)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .inc      (accept),
        .word_cnt (word_cnt),
        .buf_cnt  (buf_cnt),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LD_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LD_IDLE: if (start)          state_nxt = LD_LOAD;
            LD_LOAD: if (accept && last) state_nxt = LD_DONE;
            LD_DONE:                     state_nxt = LD_IDLE;
            default:                     state_nxt = LD_IDLE;
        endcase
    end

    // NOTE: the write-port data/address registers are reset as well, so the
    // buffer array never sees X on wr_addr/wr_data out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                wr_addr_q <= c3_wr_addr(buf_cnt, word_cnt);
                wr_data_q <= bus.in_data;
            end
        end
    end

    assign bus.we       = we_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.in_ready = (state == LD_LOAD);
    assign busy         = (state == LD_LOAD);
    assign done         = (state == LD_DONE);

`ifdef C3_SRC_LOADER_CKSUM_EN
    logic [C3_DATA_W-1:0] cksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cksum_q <= '0;
        else if (clr)    cksum_q <= '0;
        else if (accept) cksum_q <= cksum_q + bus.in_data;
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_c3_src_loader.sv
// Scoreboard bench for c3_src_loader: a 6x196 instance (full load, bubbles,
// ignored start/idle words, mid-load reset) and a 1x256 instance.
module tb_c3_src_loader;

    localparam int NB_A    = 6;
    localparam int WB_A    = 196;
    localparam int TOTAL_A = NB_A * WB_A;
    localparam int NB_B    = 1;
    localparam int WB_B    = 256;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] cksum_a, cksum_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;
    int          k_a = 0;
    logic [15:0] sum_a = '0;

    always #5 clk = ~clk;

    c3_src_loader_if if_a ();
    c3_src_loader_if if_b ();

    c3_src_loader #(.NUM_BUF(NB_A), .WORDS_PER_BUF(WB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus(if_a.slave),
        .busy(busy_a), .done(done_a), .cksum(cksum_a)
    );

    c3_src_loader #(.NUM_BUF(NB_B), .WORDS_PER_BUF(WB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus(if_b.slave),
        .busy(busy_b), .done(done_b), .cksum(cksum_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_cksum(input logic [15:0] sum);
`ifdef C3_SRC_LOADER_CKSUM_EN
        return sum;
`else
        return 16'h0000;
`endif
    endfunction

    // Monitors: pop one expectation per observed write strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (if_a.we) begin
                wr_cnt_a++;
                if (q_a.size() == 0) begin
                    check("a_unexpected_we", 32'd1, 32'd0);
                end else begin
                    e = q_a.pop_front();
                    check("a_wr_addr", if_a.wr_addr, e.addr);
                    check("a_wr_data", 32'(if_a.wr_data), 32'(e.data));
                    check("a_done", 32'(done_a), 32'(e.last));
                end
            end else if (done_a) begin
                check("a_done_without_we", 32'd1, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (if_b.we) begin
                wr_cnt_b++;
                if (q_b.size() == 0) begin
                    check("b_unexpected_we", 32'd1, 32'd0);
                end else begin
                    e = q_b.pop_front();
                    check("b_wr_addr", if_b.wr_addr, e.addr);
                    check("b_wr_data", 32'(if_b.wr_data), 32'(e.data));
                    check("b_done", 32'(done_b), 32'(e.last));
                end
            end else if (done_b) begin
                check("b_done_without_we", 32'd1, 32'd0);
            end
        end
    end

    // One cycle on instance A; load=1 means the bench expects LOAD state.
    task automatic beat_a(input logic v, input logic load);
        if_a.in_valid = v;
        if_a.in_data  = load ? 16'(k_a) : 16'hDEAD;
        @(negedge clk);
        check("a_in_ready", 32'(if_a.in_ready), 32'(load));
        check("a_busy", 32'(busy_a), 32'(load));
        @(posedge clk);
        if (v && load) begin
            q_a.push_back('{addr: {16'h0, 8'(k_a / WB_A), 8'(k_a % WB_A)},
                            data: 16'(k_a), last: (k_a == TOTAL_A - 1)});
            sum_a = sum_a + 16'(k_a);
            k_a++;
        end
        #1;
    endtask

    task automatic start_pulse_a();
        if_a.in_valid = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        k_a = 0;
        sum_a = '0;
        wr_cnt_a = 0;
    endtask

    task automatic drain(input string name, input logic use_b);
        for (int i = 0; i < 8 && (use_b ? q_b.size() : q_a.size()) != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check(name, 32'(use_b ? q_b.size() : q_a.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        if_a.in_valid = 1'b0;
        if_a.in_data = '0;
        if_b.in_valid = 1'b0;
        if_b.in_data = '0;
        #2;
        check("rst_in_ready", 32'(if_a.in_ready), 32'd0);
        check("rst_we", 32'(if_a.we), 32'd0);
        check("rst_wr_data", 32'(if_a.wr_data), 32'd0);
        check("rst_wr_addr", if_a.wr_addr, 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_cksum", 32'(cksum_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full load without bubbles; a start pulse mid-load must be ignored.
        start_pulse_a();
        while (k_a < TOTAL_A) begin
            start_a = (k_a == 500);
            beat_a(1'b1, 1'b1);
        end
        start_a = 1'b0;
        // DONE cycle: start and a valid word must both be ignored.
        start_a = 1'b1;
        if_a.in_valid = 1'b1;
        @(negedge clk);
        check("done_in_ready", 32'(if_a.in_ready), 32'd0);
        check("done_busy", 32'(busy_a), 32'd0);
        check("done_flag", 32'(done_a), 32'd1);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (3) beat_a(1'b1, 1'b0);
        if_a.in_valid = 1'b0;
        drain("full_drain", 1'b0);
        check("full_we_count", 32'(wr_cnt_a), 32'(TOTAL_A));
        check("full_cksum", 32'(cksum_a), 32'(exp_cksum(sum_a)));

        // Random 50% bubbles: same address/data sequence.
        start_pulse_a();
        while (k_a < TOTAL_A) beat_a(1'($urandom_range(0, 1)), 1'b1);
        beat_a(1'b0, 1'b0);
        drain("bubble_drain", 1'b0);
        check("bubble_we_count", 32'(wr_cnt_a), 32'(TOTAL_A));
        check("bubble_cksum_hold", 32'(cksum_a), 32'(exp_cksum(sum_a)));

        // Reset after beat 300, then a fresh load restarts at address 0.
        start_pulse_a();
        while (k_a <= 300) beat_a(1'b1, 1'b1);
        if_a.in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(if_a.in_ready), 32'd0);
        check("mid_rst_we", 32'(if_a.we), 32'd0);
        check("mid_rst_wr_data", 32'(if_a.wr_data), 32'd0);
        check("mid_rst_wr_addr", if_a.wr_addr, 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_done", 32'(done_a), 32'd0);
        check("mid_rst_cksum", 32'(cksum_a), 32'd0);
        check("mid_rst_queue", 32'(q_a.size()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) beat_a(1'b1, 1'b0);
        start_pulse_a();
        repeat (5) beat_a(1'b1, 1'b1);
        if_a.in_valid = 1'b0;
        drain("restart_drain", 1'b0);
        check("restart_we_count", 32'(wr_cnt_a), 32'd5);

        // 1x256 instance: word address spans 0x00..0xFF with no carry.
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int k = 0; k < NB_B * WB_B; k++) begin
            if_b.in_valid = 1'b1;
            if_b.in_data  = 16'(k) + 16'h1000;
            @(negedge clk);
            check("b_in_ready", 32'(if_b.in_ready), 32'd1);
            @(posedge clk);
            q_b.push_back('{addr: {24'h0, 8'(k)}, data: 16'(k) + 16'h1000,
                            last: (k == NB_B * WB_B - 1)});
            #1;
        end
        if_b.in_valid = 1'b1;
        @(negedge clk);
        check("b_ready_after_last", 32'(if_b.in_ready), 32'd0);
        @(posedge clk);
        #1;
        if_b.in_valid = 1'b0;
        drain("b_drain", 1'b1);
        check("b_we_count", 32'(wr_cnt_b), 32'(NB_B * WB_B));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
